conv1d_window_engine: RTL
=========================

Name: conv1d_window_engine

Overview:
- Downstream consumer of the 5-tap window data RAM.
- Walks read addresses 0..Last_index and drives Read_en and Address_depth_read into the RAM.
- Captures the five window taps (centre at address, ±1, ±2) and zero-masks taps outside 0..Last_index.
- Convolves the window with five latched signed weights and streams one accumulated result per address, with Out_valid and index.

Parameters:
- Bit_width, 8: width of each data sample and each weight; signed two's complement.
- Nr_depth, 512: RAM depth.
- Depth_counter_bits, 9: address width; 2**Depth_counter_bits = Nr_depth.
- Acc_width, 20: result width; must be ≥ 2*Bit_width+3.

Ports:
- Clk  in  1  single clock; all logic on posedge. The RAM samples the address on negedge.
- Reset  in  1  synchronous, active-high.
- Start  in  1  single-cycle request; accepted only in IDLE.
- Last_index  in  Depth_counter_bits  last address to process; sampled at Start.
- Weight_0..Weight_4  in  Bit_width each  signed kernel; Weight_k multiplies tap k (tap 2 = centre); sampled at Start.
- Read_en  out  1  RAM read enable.
- Address_depth_read  out  Depth_counter_bits  RAM centre address.
- Read_data_in_0..Read_data_in_4  in  Bit_width each  RAM window outputs (addr-2..addr+2).
- Out_valid  out  1  result valid.
- Out_data  out  Acc_width  signed convolution result.
- Out_index  out  Depth_counter_bits  centre address of Out_data.
- Busy  out  1  high from Start acceptance through the Done cycle.
- Done  out  1  one-cycle pulse, coincident with the last Out_valid.

Behaviour:
- Reset values: Read_en=0, Address_depth_read=0, Out_valid=0, Out_data=0, Out_index=0, Busy=0, Done=0. All pipeline valid bits are cleared; FSM returns to IDLE.
- Reset mid-run aborts immediately. No further Out_valid or Done is produced.
- FSM states: IDLE, RUN, DRAIN.
  - IDLE + Start: latch Last_index and the weights, Busy=1, go to RUN.
  - RUN: Read_en=1; Address_depth_read steps 0,1,…,Last_index, one per cycle. After issuing Last_index, go to DRAIN.
  - DRAIN: Read_en=0. Wait until the pipeline empties, then go to IDLE; Busy falls the cycle after Done.
- Start while Busy is ignored. Input changes after acceptance are ignored.
- Pipeline, with address A registered at edge k:
  - k+1: capture the 5 RAM outputs into tap regs with masking.
  - k+2: register the five signed products, each 2*Bit_width wide.
  - k+3: register the sign-extended sum into Out_data, with Out_valid=1 and Out_index=A.
  - Fixed latency: 3 cycles from address to result.
- Masking: tap0 is forced to 0 if A<2, tap1 if A<1, tap3 if A+1>Last_index, tap4 if A+2>Last_index.
  - Comparisons are done at Depth_counter_bits+1 width so wrap cannot occur. The RAM's own boundary handling is not relied upon.
- Arithmetic: signed × signed products; sum of 5 products has no overflow at Acc_width ≥ 2*Bit_width+3.
- Last_index=0: single output, taps 0,1,3,4 masked. Out_valid and Done arrive 3 cycles after the single read.
- Out_data holds its last value when Out_valid=0.

Optional Feature:
- Macro: CONV1D_RELU_EN.
- Defined: the output stage clamps negative sums to 0 (ReLU). Latency is unchanged.
- Undefined: the raw signed sum is output.

Decomposition:
- Package conv1d_pkg holds:
  - FSM state encoding (IDLE/RUN/DRAIN).
  - constant NUM_TAPS=5 and CENTRE_TAP=2.
  - an accumulator-width check constant.
- One sub-module, conv1d_mac5: registered products followed by a registered adder tree. Latency 2, with a valid-in/valid-out pipe and the optional ReLU.
- The top level holds the FSM, address counter, tap capture and masking.

Test Plan:
- RAM[i]=i+1, weights {0,0,1,0,0}, Last_index=7, Start → 8 outputs, Out_data=1..8, Out_index=0..7, Done on the 8th output, exactly 3 cycles after the last address.
- RAM[i]=1 everywhere, weights {1,1,1,1,1}, Last_index=9 → outputs 3,4,5,5,5,5,5,5,4,3 (edge masking at both ends).
- Data 8'h80 (-128), weights all 8'h80, Last_index=4 → centre output 5*16384=81920 with no overflow. With CONV1D_RELU_EN and weights all +1, all outputs are 0.
- Last_index=0, RAM[0]=5, weights {9,9,2,9,9} → single output 10, Done in the same cycle, Busy low next cycle.
- Start pulsed again during RUN, plus Weight changes mid-run → ignored; results match the original weights.
- Reset asserted two cycles into RUN with Last_index=20 → next cycle Read_en=0, Busy=0, no Out_valid or Done afterwards. A fresh Start then completes normally.

Source files
------------

// File: rtl/conv1d_pkg.sv
// Shared definitions for the 1-D window convolution engine.
// Optional build macro CONV1D_RELU_EN (used by conv1d_mac5) clamps negative results to zero.
package conv1d_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_e;

    localparam int NUM_TAPS   = 5;
    localparam int CENTRE_TAP = 2;

    // Growth of a sum of NUM_TAPS full-scale products: 5 terms need 3 extra bits.
    localparam int ACC_GUARD_BITS = 3;

    // Narrowest accumulator that can never overflow for a given sample width.
    function automatic int acc_min_width(input int bw);
        return 2 * bw + ACC_GUARD_BITS;
    endfunction

endpackage

// File: rtl/conv1d_mac5.sv
// Five-tap multiply-accumulate: registered products, then registered adder tree.
// Latency 2 cycles; a valid bit and an opaque tag ride alongside the data.
// With CONV1D_RELU_EN defined, negative sums are clamped to zero in the output stage.
module conv1d_mac5
    import conv1d_pkg::*;
#(
    parameter int Bit_width = 8,
    parameter int Acc_width = 20,
    parameter int Tag_width = 10
) (
    input  logic                        Clk,
    input  logic                        Reset,
    input  logic                        vld_i,
    input  logic signed [Bit_width-1:0] tap_i [NUM_TAPS],
    input  logic signed [Bit_width-1:0] wgt_i [NUM_TAPS],
    input  logic        [Tag_width-1:0] tag_i,
    output logic                        vld_o,
    output logic signed [Acc_width-1:0] sum_o,
    output logic        [Tag_width-1:0] tag_o
);

    localparam int PROD_W = 2 * Bit_width;
    localparam int SUM_W  = acc_min_width(Bit_width);

    logic signed [PROD_W-1:0]    prod_p2_q [NUM_TAPS];
    logic                        vld_p2_q;
    logic        [Tag_width-1:0] tag_p2_q;
    logic signed [SUM_W-1:0]     sum_p2_d;
    logic signed [Acc_width-1:0] sum_p3_q;
    logic                        vld_p3_q;
    logic        [Tag_width-1:0] tag_p3_q;

    function automatic logic signed [SUM_W-1:0] relu_clamp(input logic signed [SUM_W-1:0] x);
`ifdef CONV1D_RELU_EN
        return x[SUM_W-1] ? '0 : x;
`else
        return x;
`endif
    endfunction

    // Stage p2: one signed product per tap.
    always_ff @(posedge Clk) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
            prod_p2_q[t] <= PROD_W'(tap_i[t]) * PROD_W'(wgt_i[t]);
        end
        tag_p2_q <= tag_i;
    end

    // Stage p2 valid bit.
    always_ff @(posedge Clk) begin
        if (Reset) vld_p2_q <= 1'b0;
        else       vld_p2_q <= vld_i;
    end

    // Sign-extended sum of the registered products.
    always_comb begin
        sum_p2_d = '0;
        for (int t = 0; t < NUM_TAPS; t++) begin
            sum_p2_d = sum_p2_d + SUM_W'(prod_p2_q[t]);
        end
    end

    // Stage p3: result register, holds its value between valid beats.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            vld_p3_q <= 1'b0;
            sum_p3_q <= '0;
            tag_p3_q <= '0;
        end else begin
            vld_p3_q <= vld_p2_q;
            if (vld_p2_q) begin
                sum_p3_q <= Acc_width'(relu_clamp(sum_p2_d));
                tag_p3_q <= tag_p2_q;
            end
        end
    end

    assign vld_o = vld_p3_q;
    assign sum_o = sum_p3_q;
    assign tag_o = tag_p3_q;

endmodule

// File: rtl/conv1d_window_engine.sv
// Walks addresses 0..Last_index of a 5-tap window RAM, masks taps that fall
// outside the processed range and streams one convolution result per address.
// Optional build macro CONV1D_RELU_EN (handled in conv1d_mac5) enables ReLU output.
module conv1d_window_engine
    import conv1d_pkg::*;
#(
    parameter int Bit_width          = 8,
    parameter int Nr_depth           = 512,
    parameter int Depth_counter_bits = 9,
    parameter int Acc_width          = 20
) (
    input  logic                                 Clk,
    input  logic                                 Reset,
    input  logic                                 Start,
    input  logic        [Depth_counter_bits-1:0] Last_index,
    input  logic signed [Bit_width-1:0]          Weight_0,
    input  logic signed [Bit_width-1:0]          Weight_1,
    input  logic signed [Bit_width-1:0]          Weight_2,
    input  logic signed [Bit_width-1:0]          Weight_3,
    input  logic signed [Bit_width-1:0]          Weight_4,
    output logic                                 Read_en,
    output logic        [Depth_counter_bits-1:0] Address_depth_read,
    input  logic signed [Bit_width-1:0]          Read_data_in_0,
    input  logic signed [Bit_width-1:0]          Read_data_in_1,
    input  logic signed [Bit_width-1:0]          Read_data_in_2,
    input  logic signed [Bit_width-1:0]          Read_data_in_3,
    input  logic signed [Bit_width-1:0]          Read_data_in_4,
    output logic                                 Out_valid,
    output logic signed [Acc_width-1:0]          Out_data,
    output logic        [Depth_counter_bits-1:0] Out_index,
    output logic                                 Busy,
    output logic                                 Done
);

    localparam int D     = Depth_counter_bits;
    localparam int EXT_W = D + 1;
    localparam int TAG_W = D + 1;
    localparam logic [D-1:0] MAX_IDX = D'(Nr_depth - 1);

    state_e                      state_q, state_d;
    logic        [D-1:0]         addr_q, addr_d;
    logic                        re_q, re_d;
    logic                        accept;
    logic        [D-1:0]         last_q;
    logic signed [Bit_width-1:0] wgt_q     [NUM_TAPS];
    logic signed [Bit_width-1:0] rd        [NUM_TAPS];
    logic signed [Bit_width-1:0] win       [NUM_TAPS];
    logic signed [Bit_width-1:0] tap_p1_q  [NUM_TAPS];
    logic                        vld_p1_q;
    logic        [TAG_W-1:0]     tag_p1_q;
    logic        [EXT_W-1:0]     addr_ext, last_ext;
    logic                        vld_p3;
    logic        [TAG_W-1:0]     tag_p3;
    logic                        done;

    assign rd[0] = Read_data_in_0;
    assign rd[1] = Read_data_in_1;
    assign rd[2] = Read_data_in_2;
    assign rd[3] = Read_data_in_3;
    assign rd[4] = Read_data_in_4;

    // The final result carries a flag in its tag's top bit.
    assign done = vld_p3 & tag_p3[D];

    // Next state, read enable and address counter.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        re_d    = 1'b0;
        accept  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (Start) begin
                    accept  = 1'b1;
                    state_d = ST_RUN;
                    addr_d  = '0;
                    re_d    = 1'b1;
                end
            end
            ST_RUN: begin
                if (addr_q == last_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    addr_d = addr_q + 1'b1;
                    re_d   = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (done) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and read-port registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            addr_q  <= '0;
            re_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            re_q    <= re_d;
        end
    end

    // Job parameters are frozen at acceptance; a Last_index beyond the RAM is clamped.
    always_ff @(posedge Clk) begin
        if (accept) begin
            last_q   <= (Last_index > MAX_IDX) ? MAX_IDX : Last_index;
            wgt_q[0] <= Weight_0;
            wgt_q[1] <= Weight_1;
            wgt_q[2] <= Weight_2;
            wgt_q[3] <= Weight_3;
            wgt_q[4] <= Weight_4;
        end
    end

    // Zero taps whose address lies outside 0..last; one extra bit keeps A+2 from wrapping.
    assign addr_ext = {1'b0, addr_q};
    assign last_ext = {1'b0, last_q};

    always_comb begin
        for (int t = 0; t < NUM_TAPS; t++) begin
            win[t] = '0;
            if (t < CENTRE_TAP) begin
                if (addr_ext >= EXT_W'(CENTRE_TAP - t)) win[t] = rd[t];
            end else begin
                if ((addr_ext + EXT_W'(t - CENTRE_TAP)) <= last_ext) win[t] = rd[t];
            end
        end
    end

    // Stage p1: capture the masked window with its centre address and last-address flag.
    always_ff @(posedge Clk) begin
        for (int t = 0; t < NUM_TAPS; t++) begin
            tap_p1_q[t] <= win[t];
        end
        tag_p1_q <= {addr_q == last_q, addr_q};
    end

    // Stage p1 valid bit follows the read enable by one cycle.
    always_ff @(posedge Clk) begin
        if (Reset) vld_p1_q <= 1'b0;
        else       vld_p1_q <= re_q;
    end

    conv1d_mac5 #(
        .Bit_width (Bit_width),
        .Acc_width (Acc_width),
        .Tag_width (TAG_W)
    ) u_mac5 (
        .Clk   (Clk),
        .Reset (Reset),
        .vld_i (vld_p1_q),
        .tap_i (tap_p1_q),
        .wgt_i (wgt_q),
        .tag_i (tag_p1_q),
        .vld_o (vld_p3),
        .sum_o (Out_data),
        .tag_o (tag_p3)
    );

    assign Read_en            = re_q;
    assign Address_depth_read = addr_q;
    assign Busy               = (state_q != ST_IDLE);
    assign Out_valid          = vld_p3;
    assign Out_index          = tag_p3[D-1:0];
    assign Done               = done;

endmodule
